// File: rtl/median_pkg.sv
// Shared widths, derived depths and controller state encoding for the median filter host side.
`timescale 1ns/1ps
package median_pkg;
  localparam int unsigned A_WIDTH   = 8;
  localparam int unsigned D_WIDTH   = 8;
  localparam int unsigned R_WIDTH   = 3;
  localparam int unsigned RC_WIDTH  = A_WIDTH - R_WIDTH;
  localparam int unsigned OUT_DEPTH = 2 ** RC_WIDTH;
  localparam int unsigned FRAME_LEN = 2 ** A_WIDTH;

  typedef enum logic [2:0] {
    FILL = 3'd0,
    GO   = 3'd1,
    WAIT = 3'd2,
    RD   = 3'd3,
    CAP  = 3'd4,
    EMIT = 3'd5
  } state_t;
endpackage

// File: rtl/median_feeder.sv
// Host-side feeder: fills sample memory A, kicks the median engine, then streams
// its results out of the output memory over a valid/ready port.
`timescale 1ns/1ps
module median_feeder
  import median_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  input  logic [D_WIDTH-1:0]  In_Data,
  input  logic                In_Valid,
  output logic                In_Ready,
  output logic [A_WIDTH-1:0]  A_Addr,
  output logic [D_WIDTH-1:0]  A_WData,
  output logic                A_RW,
  output logic                A_EN,
  output logic                Go,
  input  logic                Done,
  output logic                Mem_Sel,
  output logic [RC_WIDTH-1:0] Out_Addr,
  input  logic [D_WIDTH-1:0]  Out_RData,
  output logic                Out_RW,
  output logic                Out_EN,
  output logic [D_WIDTH-1:0]  Res_Data,
  output logic                Res_Valid,
  input  logic                Res_Ready,
  output logic                Frame_Done
);

  state_t               state, state_d;
  logic [A_WIDTH-1:0]   wr_cnt, wr_cnt_d;
  logic [RC_WIDTH-1:0]  rd_cnt, rd_cnt_d;
  logic                 go_d, sel_d, valid_d, frame_done_d;
  logic [D_WIDTH-1:0]   data_d;

  // Memory strobes follow the current state directly so writes land in the accepting cycle.
  always_comb begin
    In_Ready = (state == FILL);
    A_EN     = (state == FILL) && In_Valid;
    A_RW     = (state == FILL) && In_Valid;
    A_Addr   = wr_cnt;
    A_WData  = In_Data;
    Out_EN   = (state == RD);
    Out_RW   = 1'b0;
    Out_Addr = rd_cnt;
  end

  // Next-state and next values of the registered outputs.
  always_comb begin
    state_d      = state;
    wr_cnt_d     = wr_cnt;
    rd_cnt_d     = rd_cnt;
    go_d         = 1'b0;
    frame_done_d = 1'b0;
    valid_d      = Res_Valid;
    data_d       = Res_Data;
    case (state)
      FILL: begin
        if (In_Valid) begin
          wr_cnt_d = wr_cnt + A_WIDTH'(1);
          if (wr_cnt == A_WIDTH'(FRAME_LEN - 1)) begin
            state_d = GO;
            go_d    = 1'b1;
          end
        end
      end
      GO:   state_d = WAIT;
      WAIT: if (Done) state_d = RD;
      RD:   state_d = CAP;
      CAP: begin
        data_d  = Out_RData;
        valid_d = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (Res_Ready) begin
          valid_d = 1'b0;
          if (rd_cnt == RC_WIDTH'(OUT_DEPTH - 1)) begin
            rd_cnt_d     = '0;
            frame_done_d = 1'b1;
            state_d      = FILL;
          end else begin
            rd_cnt_d = rd_cnt + RC_WIDTH'(1);
            state_d  = RD;
          end
        end
      end
      default: state_d = FILL;
    endcase
    // The engine owns both memories for exactly the GO..WAIT window.
    sel_d = (state_d == GO) || (state_d == WAIT);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      Go         <= 1'b0;
      Mem_Sel    <= 1'b0;
      Res_Valid  <= 1'b0;
      Res_Data   <= '0;
      Frame_Done <= 1'b0;
    end else begin
      state      <= state_d;
      wr_cnt     <= wr_cnt_d;
      rd_cnt     <= rd_cnt_d;
      Go         <= go_d;
      Mem_Sel    <= sel_d;
      Res_Valid  <= valid_d;
      Res_Data   <= data_d;
      Frame_Done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_median_feeder.sv
// Self-checking bench for median_feeder: models the output memory and scoreboards the result stream.
`timescale 1ns/1ps
module tb_median_feeder;
  import median_pkg::*;

  logic                Clk;
  logic                Rst;
  logic [D_WIDTH-1:0]  In_Data;
  logic                In_Valid;
  logic                In_Ready;
  logic [A_WIDTH-1:0]  A_Addr;
  logic [D_WIDTH-1:0]  A_WData;
  logic                A_RW;
  logic                A_EN;
  logic                Go;
  logic                Done;
  logic                Mem_Sel;
  logic [RC_WIDTH-1:0] Out_Addr;
  logic [D_WIDTH-1:0]  Out_RData;
  logic                Out_RW;
  logic                Out_EN;
  logic [D_WIDTH-1:0]  Res_Data;
  logic                Res_Valid;
  logic                Res_Ready;
  logic                Frame_Done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int go_cnt    = 0;
  int fd_cnt    = 0;
  logic [D_WIDTH-1:0] out_mem [OUT_DEPTH];
  logic [D_WIDTH-1:0] exp_q [$];

  median_feeder dut (
    .Clk(Clk), .Rst(Rst), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .A_Addr(A_Addr), .A_WData(A_WData), .A_RW(A_RW), .A_EN(A_EN), .Go(Go), .Done(Done),
    .Mem_Sel(Mem_Sel), .Out_Addr(Out_Addr), .Out_RData(Out_RData), .Out_RW(Out_RW),
    .Out_EN(Out_EN), .Res_Data(Res_Data), .Res_Valid(Res_Valid), .Res_Ready(Res_Ready),
    .Frame_Done(Frame_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Output memory model: registered read, data valid the cycle after the enable.
  always @(posedge Clk) if (Out_EN === 1'b1) Out_RData <= out_mem[Out_Addr];

  always @(posedge Clk) begin
    if (Go === 1'b1) go_cnt <= go_cnt + 1;
    if (Frame_Done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic test_reset();
    logic [8:0] obs;
    Rst = 1'b0; In_Valid = 1'b0; In_Data = '0; Done = 1'b0; Res_Ready = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    obs = {Go, Mem_Sel, Res_Valid, Frame_Done, A_EN, A_RW, Out_EN, Out_RW, In_Ready};
    total_cnt++;
    if (obs !== 9'b000000001) $display("FAIL reset_ctl: got %b expected %b", obs, 9'b000000001);
    else pass_cnt++;
    total_cnt++;
    if (Res_Data !== 8'h00) $display("FAIL reset_data: got %h expected 00", Res_Data);
    else pass_cnt++;
    @(posedge Clk); #1;
    Rst = 1'b1;
  endtask

  task automatic test_fill(input bit gap, input bit spur, input logic [7:0] base);
    int k = 0;
    int cyc = 0;
    int go0;
    bit v;
    logic [7:0] d;
    logic [5:0] obs, exp;
    logic [4:0] gobs;
    go0 = go_cnt;
    while (k < FRAME_LEN && cyc < 1000) begin
      v = gap ? (cyc % 3 == 0) : 1'b1;
      d = base + 8'(k);
      In_Valid = v; In_Data = d; Done = spur && (cyc == 10);
      @(negedge Clk);
      obs = {In_Ready, Go, Mem_Sel, A_EN, A_RW, Out_EN};
      exp = {1'b1, 1'b0, 1'b0, v, v, 1'b0};
      total_cnt++;
      if (obs !== exp) $display("FAIL fill_ctl[%0d]: got %b expected %b", cyc, obs, exp);
      else pass_cnt++;
      if (v) begin
        total_cnt++;
        if ({A_Addr, A_WData} !== {8'(k), d})
          $display("FAIL fill_write[%0d]: got addr %h data %h expected addr %h data %h",
                   k, A_Addr, A_WData, 8'(k), d);
        else pass_cnt++;
      end
      @(posedge Clk); #1;
      if (v) k++;
      cyc++;
    end
    Done = 1'b0;
    total_cnt++;
    if (k != FRAME_LEN) $display("FAIL fill_count: got %0d expected %0d", k, FRAME_LEN);
    else pass_cnt++;
    // A sample offered during GO must be refused with no strobe.
    In_Valid = 1'b1; In_Data = 8'hEE;
    @(negedge Clk);
    gobs = {In_Ready, Go, Mem_Sel, A_EN, Out_EN};
    total_cnt++;
    if (gobs !== 5'b01100) $display("FAIL go_cycle: got %b expected %b", gobs, 5'b01100);
    else pass_cnt++;
    @(posedge Clk); #1;
    total_cnt++;
    if (go_cnt != go0 + 1) $display("FAIL go_pulses: got %0d expected %0d", go_cnt - go0, 1);
    else pass_cnt++;
  endtask

  task automatic test_readback(input bit bp);
    int waits;
    int fd0;
    logic [7:0] exp;
    logic [5:0] obs;
    for (int c = 1; c < 40; c++) begin
      In_Valid = 1'b1;
      @(negedge Clk);
      obs = {Mem_Sel, In_Ready, A_EN, Out_EN, Res_Valid, Go};
      total_cnt++;
      if (obs !== 6'b100000) $display("FAIL wait_ctl[%0d]: got %b expected %b", c, obs, 6'b100000);
      else pass_cnt++;
      @(posedge Clk); #1;
    end
    In_Valid = 1'b0;
    Done = 1'b1;
    for (int j = 0; j < OUT_DEPTH; j++) exp_q.push_back(8'(3 * j));
    @(posedge Clk); #1;
    Done = 1'b0;
    fd0 = fd_cnt;
    Res_Ready = 1'b1;
    for (int j = 0; j < OUT_DEPTH; j++) begin
      if (bp && j == 7) Res_Ready = 1'b0;
      waits = 0;
      @(negedge Clk);
      while (Res_Valid !== 1'b1 && waits < 8) begin
        if (Out_EN === 1'b1) begin
          total_cnt++;
          if ({Mem_Sel, Out_RW, Out_Addr} !== {2'b00, 5'(j)})
            $display("FAIL rd_addr[%0d]: got sel/rw/addr %b expected %b", j,
                     {Mem_Sel, Out_RW, Out_Addr}, {2'b00, 5'(j)});
          else pass_cnt++;
        end
        @(posedge Clk); #1;
        waits++;
        @(negedge Clk);
      end
      total_cnt++;
      if (Res_Valid !== 1'b1 || waits != 2) begin
        $display("FAIL res_latency[%0d]: got valid %b after %0d cycles expected 1 after 2", j, Res_Valid, waits);
        if (Res_Valid !== 1'b1) begin
          exp_q.delete();
          return;
        end
      end else pass_cnt++;
      exp = exp_q.pop_front();
      total_cnt++;
      if (Res_Data !== exp) $display("FAIL res_data[%0d]: got %0d expected %0d", j, Res_Data, exp);
      else pass_cnt++;
      if (bp && j == 7) begin
        for (int s = 0; s < 5; s++) begin
          total_cnt++;
          if ({Res_Valid, Out_EN, Res_Data} !== {2'b10, exp})
            $display("FAIL stall[%0d]: got valid/en/data %b/%b/%0d expected 1/0/%0d",
                     s, Res_Valid, Out_EN, Res_Data, exp);
          else pass_cnt++;
          @(posedge Clk); #1;
        end
        Res_Ready = 1'b1;
        @(negedge Clk);
        total_cnt++;
        if ({Res_Valid, Res_Data} !== {1'b1, exp})
          $display("FAIL stall_release: got valid/data %b/%0d expected 1/%0d", Res_Valid, Res_Data, exp);
        else pass_cnt++;
      end
      total_cnt++;
      if (fd_cnt != fd0) $display("FAIL early_frame_done[%0d]: got %0d expected %0d", j, fd_cnt - fd0, 0);
      else pass_cnt++;
      @(posedge Clk); #1;
    end
    @(negedge Clk);
    obs = {Frame_Done, Res_Valid, In_Ready, Mem_Sel, Out_EN, Go};
    total_cnt++;
    if (obs !== 6'b101000) $display("FAIL frame_done: got %b expected %b", obs, 6'b101000);
    else pass_cnt++;
    @(posedge Clk); #1;
    @(negedge Clk);
    total_cnt++;
    if (Frame_Done !== 1'b0 || fd_cnt != fd0 + 1)
      $display("FAIL frame_done_pulse: got level %b count %0d expected 0 1", Frame_Done, fd_cnt - fd0);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size());
    else pass_cnt++;
    @(posedge Clk); #1;
  endtask

  task automatic test_mid_reset();
    logic [6:0] obs;
    // Called with the block in WAIT.
    In_Valid = 1'b0;
    #3 Rst = 1'b0;
    #1;
    obs = {Go, Mem_Sel, Res_Valid, Frame_Done, A_EN, Out_EN, In_Ready};
    total_cnt++;
    if (obs !== 7'b0000001) $display("FAIL mid_reset_ctl: got %b expected %b", obs, 7'b0000001);
    else pass_cnt++;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      In_Valid = 1'b1; In_Data = 8'(8'h50 + i);
      @(negedge Clk);
      total_cnt++;
      if ({A_EN, A_Addr, A_WData} !== {1'b1, 8'(i), 8'(8'h50 + i)})
        $display("FAIL after_reset_write[%0d]: got en/addr/data %b/%h/%h expected 1/%h/%h",
                 i, A_EN, A_Addr, A_WData, 8'(i), 8'(8'h50 + i));
      else pass_cnt++;
      @(posedge Clk); #1;
    end
    // Reset in the middle of a partial frame discards it.
    In_Valid = 1'b0;
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    In_Valid = 1'b1; In_Data = 8'h77;
    @(negedge Clk);
    total_cnt++;
    if ({A_EN, A_Addr, A_WData} !== {1'b1, 8'h00, 8'h77})
      $display("FAIL partial_discard: got en/addr/data %b/%h/%h expected 1/00/77", A_EN, A_Addr, A_WData);
    else pass_cnt++;
    @(posedge Clk); #1;
    In_Valid = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < OUT_DEPTH; j++) out_mem[j] = 8'(3 * j);
    Out_RData = '0;
    test_reset();
    test_fill(1'b0, 1'b0, 8'h00);
    test_readback(1'b1);
    test_fill(1'b1, 1'b1, 8'hA0);
    test_readback(1'b0);
    test_fill(1'b0, 1'b0, 8'h33);
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
